// File: rtl/report_stream_arbiter_if.sv
// Handshake bundle between NUM_SRC byte-stream sources, the arbiter and one byte sink.
// master is the arbiter's view; slave is the view of whatever surrounds it.
interface report_stream_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [8*NUM_SRC-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC-1:0]   src_require;
  logic [7:0]           out_data;
  logic                 out_valid;
  logic                 out_require;
  logic [NUM_SRC-1:0]   grant;
  logic                 busy;
  logic                 burst_cut;

  modport master (
    input  src_data, src_valid, out_require,
    output src_require, out_data, out_valid, grant, busy, burst_cut
  );

  modport slave (
    output src_data, src_valid, out_require,
    input  src_require, out_data, out_valid, grant, busy, burst_cut
  );
endinterface

// File: rtl/report_stream_arbiter.sv
// Round-robin, message-granular arbiter sharing one byte sink between NUM_SRC sources.
// A grant lasts until the owner drops valid or MAX_BURST bytes have been sent.
module report_stream_arbiter #(
  parameter int NUM_SRC   = 2,
  parameter int MAX_BURST = 128
) (
  input logic                     clk,
  input logic                     rst,
  report_stream_arbiter_if.master bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [CW-1:0]      count_q, count_d;
  logic               cut_q, cut_d;

  logic [IW-1:0]      winner, cand;
  logic               any_valid;
  logic               owner_valid;
  logic               xfer;
  logic [7:0]         owner_data;

  // Offsets are walked from NUM_SRC down to 1 so the nearest requester after last_q is kept.
  always_comb begin
    winner    = last_q;
    cand      = last_q;
    any_valid = 1'b0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand = IW'((int'(last_q) + k) % NUM_SRC);
      if (bus.src_valid[cand]) begin
        winner    = cand;
        any_valid = 1'b1;
      end
    end
  end

  // grant_q is one-hot or zero, so an AND-OR mux yields 8'h00 while idle.
  always_comb begin
    owner_data = 8'h00;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) owner_data = owner_data | bus.src_data[8*i +: 8];
    end
  end

  assign owner_valid = |(grant_q & bus.src_valid);
  assign xfer        = owner_valid & bus.out_require;

  assign bus.out_valid   = owner_valid;
  assign bus.out_data    = owner_data;
  assign bus.src_require = grant_q & bus.src_valid & {NUM_SRC{bus.out_require}};
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q == S_GRANT);
  assign bus.burst_cut   = cut_q;

  // NOTE: every signal gets its hold value before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    count_d = count_q;
    cut_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d = S_GRANT;
          grant_d = NUM_SRC'(1) << winner;
          last_d  = winner;
          count_d = '0;
        end
      end
      S_GRANT: begin
        if (xfer) count_d = count_q + 1'b1;
        // The burst limit takes priority so a cut is still flagged if valid also drops.
        if (xfer && (count_q == CW'(MAX_BURST - 1))) begin
          state_d = S_IDLE;
          grant_d = '0;
          cut_d   = 1'b1;
        end else if (!owner_valid) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NUM_SRC - 1);
      count_q <= '0;
      cut_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      count_q <= count_d;
      cut_q   <= cut_d;
    end
  end
endmodule

// File: tb/tb_report_stream_arbiter.sv
// Bench for report_stream_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the arbitration rules.
module tb_report_stream_arbiter;
  localparam int NA = 2;
  localparam int BA = 128;
  localparam int NB = 3;
  localparam int BB = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [7:0] req;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       cut;
  } outs_t;

  typedef logic [7:0] bq_t [$];

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sdata [8];
  logic [7:0] svalid;
  logic       oreq;
  logic       sel;

  always #5 clk = ~clk;

  report_stream_arbiter_if #(.NUM_SRC(NA)) bus_a ();
  report_stream_arbiter_if #(.NUM_SRC(NB)) bus_b ();

  report_stream_arbiter #(.NUM_SRC(NA), .MAX_BURST(BA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  report_stream_arbiter #(.NUM_SRC(NB), .MAX_BURST(BB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  for (genvar gi = 0; gi < NA; gi++) begin : g_da
    assign bus_a.src_data[8*gi +: 8] = sdata[gi];
  end
  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    assign bus_b.src_data[8*gi +: 8] = sdata[gi];
  end
  assign bus_a.src_valid   = svalid[NA-1:0];
  assign bus_b.src_valid   = svalid[NB-1:0];
  assign bus_a.out_require = oreq;
  assign bus_b.out_require = oreq;

  // Source agents, model state and transfer log.
  bq_t  msg [8];
  int   n_src, max_b;
  int   m_owner = -1;
  int   m_last  = 0;
  int   m_cnt   = 0;
  logic m_cut   = 1'b0;
  int   cyc     = 0;
  int   total   = 0;
  int   bad     = 0;
  int   cut_seen, cut_cyc;
  int   log_src [$];
  int   log_cyc [$];
  logic [7:0] log_byte [$];

  function automatic outs_t observe();
    outs_t o;
    if (sel) begin
      o.grant = 8'(bus_b.grant);  o.req   = 8'(bus_b.src_require);
      o.data  = bus_b.out_data;   o.valid = bus_b.out_valid;
      o.busy  = bus_b.busy;       o.cut   = bus_b.burst_cut;
    end else begin
      o.grant = 8'(bus_a.grant);  o.req   = 8'(bus_a.src_require);
      o.data  = bus_a.out_data;   o.valid = bus_a.out_valid;
      o.busy  = bus_a.busy;       o.cut   = bus_a.burst_cut;
    end
    return o;
  endfunction

  function automatic outs_t model_expect();
    outs_t o;
    o = '0;
    o.cut = m_cut;
    if (m_owner >= 0) begin
      o.grant        = 8'(1) << m_owner;
      o.valid        = svalid[m_owner];
      o.data         = sdata[m_owner];
      o.req[m_owner] = oreq & svalid[m_owner];
      o.busy         = 1'b1;
    end
    return o;
  endfunction

  function automatic void model_update();
    if (rst) begin
      m_owner = -1; m_last = n_src - 1; m_cnt = 0; m_cut = 1'b0;
    end else if (m_owner < 0) begin
      m_cut = 1'b0;
      for (int k = 1; k <= n_src; k++) begin
        int c;
        c = (m_last + k) % n_src;
        if (svalid[c]) begin
          m_owner = c; m_last = c; m_cnt = 0;
          break;
        end
      end
    end else begin
      m_cut = 1'b0;
      if (svalid[m_owner] && oreq) begin
        m_cnt++;
        if (m_cnt == max_b) begin
          m_owner = -1; m_cut = 1'b1;
        end
      end
      if (m_owner >= 0 && !svalid[m_owner]) m_owner = -1;
    end
  endfunction

  function automatic int onehot_idx(input logic [7:0] g);
    int r = -1;
    for (int i = 0; i < 8; i++) if (g[i]) r = i;
    return r;
  endfunction

  function automatic logic [63:0] src_seq();
    logic [63:0] s = '0;
    foreach (log_src[i]) s = (s << 4) | 64'(log_src[i] + 1);
    return s;
  endfunction

  task automatic load(input int s, input int len, input int base);
    for (int j = 0; j < len; j++) msg[s].push_back(8'(base + j));
  endtask

  task automatic prep();
    for (int i = 0; i < 8; i++) begin
      svalid[i] = (msg[i].size() != 0);
      sdata[i]  = (msg[i].size() != 0) ? msg[i][0] : 8'($urandom);
    end
    #1;
  endtask

  task automatic tick();
    outs_t o;
    o = observe();
    @(posedge clk);
    model_update();
    if (o.valid === 1'b1 && oreq) begin
      log_src.push_back(onehot_idx(o.grant));
      log_byte.push_back(o.data);
      log_cyc.push_back(cyc);
    end
    if (o.cut === 1'b1) begin
      cut_seen++;
      cut_cyc = cyc;
    end
    for (int i = 0; i < 8; i++) begin
      if (rst) msg[i].delete();
      else if (o.req[i] === 1'b1 && msg[i].size() != 0) void'(msg[i].pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_all(input logic s);
    sel   = s;
    n_src = s ? NB : NA;
    max_b = s ? BB : BA;
    for (int i = 0; i < 8; i++) msg[i].delete();
    oreq = 1'b0;
    rst  = 1'b1;
    repeat (2) begin prep(); tick(); end
    rst = 1'b0;
    log_src.delete(); log_byte.delete(); log_cyc.delete();
    cut_seen = 0; cut_cyc = -1;
  endtask

  task automatic test_reset();
    outs_t obs, exp;
    reset_all(1'b0);
    prep();
    obs = observe(); exp = model_expect();
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    total++;
    if (obs !== exp) begin bad++; $display("FAIL reset_model got=%h exp=%h", obs, exp); end
    tick();
  endtask

  task automatic test_single();
    outs_t obs, exp;
    int c0;
    reset_all(1'b0);
    load(0, 3, 'h41); oreq = 1'b1; c0 = cyc;
    repeat (8) begin
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      if (cyc == c0 + 1) begin
        total++;
        if (obs.grant !== 8'h01 || obs.data !== 8'h41)
          begin bad++; $display("FAIL single_first_grant grant=%h data=%h want 01/41", obs.grant, obs.data); end
      end
      tick();
    end
    total++;
    if (log_byte.size() != 3 || {log_byte[0], log_byte[1], log_byte[2]} !== 24'h414243)
      begin bad++; $display("FAIL single_bytes n=%0d want 41,42,43", log_byte.size()); end
    total++;
    if (log_cyc.size() != 3 || log_cyc[0] != c0 + 1 || log_cyc[2] != c0 + 3)
      begin bad++; $display("FAIL single_latency n=%0d first=%0d want %0d", log_cyc.size(), (log_cyc.size() != 0) ? log_cyc[0] : -1, c0 + 1); end
  endtask

  task automatic test_both_valid();
    outs_t obs, exp;
    reset_all(1'b0);
    load(0, 3, 'h10); load(1, 2, 'h20); oreq = 1'b1;
    repeat (12) begin
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL both_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      tick();
    end
    total++;
    if (src_seq() !== 64'h11122) begin bad++; $display("FAIL both_order got=%h want=11122", src_seq()); end
    total++;
    if (log_cyc.size() != 5 || log_cyc[3] - log_cyc[2] != 3)
      begin bad++; $display("FAIL both_gap n=%0d want 3-cycle spacing across release", log_cyc.size()); end
  endtask

  task automatic test_no_interleave();
    outs_t obs, exp;
    reset_all(1'b0);
    load(0, 10, 'h30); oreq = 1'b1;
    for (int n = 0; n < 26; n++) begin
      if (n == 4) load(1, 5, 'hA0);
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL interleave_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      tick();
    end
    total++;
    if (src_seq() !== 64'h111111111122222) begin bad++; $display("FAIL interleave_order got=%h want=111111111122222", src_seq()); end
  endtask

  task automatic test_burst_cut();
    outs_t obs, exp;
    reset_all(1'b1);
    load(0, 6, 'h50); load(1, 3, 'hB0); oreq = 1'b1;
    repeat (20) begin
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL burst_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      tick();
    end
    total++;
    if (src_seq() !== 64'h111122211) begin bad++; $display("FAIL burst_order got=%h want=111122211", src_seq()); end
    total++;
    if (cut_seen != 1 || log_cyc.size() < 4 || cut_cyc != log_cyc[3] + 1)
      begin bad++; $display("FAIL burst_pulse count=%0d at=%0d want one pulse after 4th byte", cut_seen, cut_cyc); end
  endtask

  task automatic test_backpressure();
    outs_t obs, exp;
    logic [7:0] held;
    logic ok;
    reset_all(1'b0);
    load(0, 8, 'h50); oreq = 1'b1;
    held = 8'h00;
    for (int n = 0; n < 24; n++) begin
      oreq = !(n >= 3 && n < 8);
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL bp_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      if (n == 3) held = obs.data;
      if (n > 3 && n < 8) begin
        total++;
        if (obs.data !== held || obs.req !== 8'h00 || obs.grant !== 8'h01)
          begin bad++; $display("FAIL bp_stall data=%h req=%h grant=%h want %h/00/01", obs.data, obs.req, obs.grant, held); end
      end
      tick();
    end
    ok = (log_byte.size() == 8);
    for (int j = 0; j < 8; j++) if (ok && log_byte[j] !== 8'(8'h50 + j)) ok = 1'b0;
    total++;
    if (!ok) begin bad++; $display("FAIL bp_bytes n=%0d want 50..57 once each", log_byte.size()); end
  endtask

  task automatic test_reset_mid();
    outs_t obs, exp;
    reset_all(1'b0);
    load(0, 6, 'h60); oreq = 1'b1;
    for (int k = 0; k < 10 && log_byte.size() < 2; k++) begin
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL rstmid_cycle cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      tick();
    end
    total++;
    if (log_byte.size() != 2) begin bad++; $display("FAIL rstmid_reach n=%0d want 2 (timeout)", log_byte.size()); end
    rst = 1'b1;
    prep(); obs = observe(); exp = model_expect(); total++;
    if (obs !== exp) begin bad++; $display("FAIL rstmid_byte3 got=%h exp=%h", obs, exp); end
    tick();
    rst = 1'b0;
    prep(); obs = observe(); total++;
    if ({obs.grant, obs.valid, obs.busy} !== 10'b0)
      begin bad++; $display("FAIL rstmid_drop grant=%h valid=%b busy=%b want 0", obs.grant, obs.valid, obs.busy); end
    log_src.delete(); log_byte.delete(); log_cyc.delete();
    load(0, 3, 'h70); load(1, 3, 'h80);
    repeat (14) begin
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL rstmid_post cyc=%0d got=%h exp=%h", cyc, obs, exp); end
      tick();
    end
    total++;
    if (src_seq() !== 64'h111222) begin bad++; $display("FAIL rstmid_order got=%h want=111222", src_seq()); end
  endtask

  task automatic test_random(input logic s);
    outs_t obs, exp;
    reset_all(s);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < n_src; i++)
        if (msg[i].size() == 0 && $urandom_range(0, 3) == 0)
          load(i, int'($urandom_range(1, 7)), int'($urandom_range(0, 255)));
      oreq = ($urandom_range(0, 3) != 0);
      prep(); obs = observe(); exp = model_expect(); total++;
      if (obs !== exp) begin bad++; $display("FAIL random%0d cyc=%0d got=%h exp=%h", s, cyc, obs, exp); end
      tick();
    end
    total++;
    if (log_byte.size() < 50) begin bad++; $display("FAIL random%0d_progress bytes=%0d want >=50", s, log_byte.size()); end
  endtask

  initial begin
    rst = 1'b1; oreq = 1'b0; svalid = '0; sel = 1'b0;
    for (int i = 0; i < 8; i++) sdata[i] = 8'h00;
    @(negedge clk);
    test_reset();
    test_single();
    test_both_valid();
    test_no_interleave();
    test_burst_cut();
    test_backpressure();
    test_reset_mid();
    test_random(1'b0);
    test_random(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
